// File: rtl/alu_operand_issue.sv
// Operand-issue stage in front of the 24-bit ALU.
//
// Holds the register file and a per-register pending-write scoreboard.
// Decoded instructions arrive over in_valid/in_ready. Operands come from the
// register file, the sign-extended immediate, or the writeback port in the
// same cycle (bypass). The stage stalls on RAW and WAW hazards and presents
// registered operands through a one-entry valid/ready output slice.
//
// Ports
//   clk, reset_n                      clock (rising edge), async active-low reset
//   in_valid/in_ready                 instruction handshake
//   in_op, in_rs, in_rt, in_imm,
//   in_use_imm, in_rd, in_wr_en       decoded instruction fields
//   out_valid/out_ready               ALU-side handshake
//   alu_a, alu_b, alu_op,
//   out_rd, out_wr_en                 registered outputs to the ALU / EX stage
//   wb_valid, wb_addr, wb_data        writeback port
//   flush                             kill the instruction held in the output slice
module alu_operand_issue #(
  parameter int DATA_W = 24,
  parameter int OP_W   = 3,
  parameter int RA_W   = 3,
  parameter int IMM_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RA_W-1:0]   in_rs,
  input  logic [RA_W-1:0]   in_rt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_wr_en,
  input  logic              wb_valid,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  localparam int NREG = 2 ** RA_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pend_nxt;
  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   p_eff;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] imm_sext;
  logic              wr_eff;
  logic              stall;
  logic              accept;

  // One-hot of the register being written back this cycle; R0 never hits.
  always_comb begin
    wb_hit = '0;
    for (int r = 1; r < NREG; r++) begin
      wb_hit[r] = wb_valid && (wb_addr == RA_W'(r));
    end
  end

  // A writeback landing this cycle resolves the hazard it clears.
  assign p_eff    = pending & ~wb_hit;
  assign imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign wr_eff   = in_wr_en && (in_rd != '0);

  always_comb begin
    rd_a = '0;
    if (in_rs != '0) begin
      rd_a = wb_hit[in_rs] ? wb_data : regs[in_rs];
    end
  end

  always_comb begin
    rd_b = '0;
    if (in_use_imm) begin
      rd_b = imm_sext;
    end else if (in_rt != '0) begin
      rd_b = wb_hit[in_rt] ? wb_data : regs[in_rt];
    end
  end

  assign stall = p_eff[in_rs]
               | (~in_use_imm & p_eff[in_rt])
               | (wr_eff & p_eff[in_rd]);

  // Deliberately independent of in_valid.
  assign in_ready = ~stall & ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Clear by writeback or flush first, then set by a new writer so that a
  // set and clear of the same register in one edge leaves it pending.
  always_comb begin
    pend_nxt = pending & ~wb_hit;
    if (flush && out_valid && out_wr_en) begin
      pend_nxt[out_rd] = 1'b0;
    end
    if (accept && wr_eff) begin
      pend_nxt[in_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      pending <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wb_hit[r]) begin
          regs[r] <= wb_data;
        end
      end
      pending <= pend_nxt;
    end
  end

  // Output slice: load on accept, drop on flush or consume, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_rd    <= '0;
      out_wr_en <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_a     <= rd_a;
      alu_b     <= rd_b;
      alu_op    <= in_op;
      out_rd    <= in_rd;
      out_wr_en <= wr_eff;
    end else if (flush || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic [11:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_rd;
  logic        in_wr_en;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] alu_a;
  logic [23:0] alu_b;
  logic [2:0]  alu_op;
  logic [2:0]  out_rd;
  logic        out_wr_en;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [23:0] wb_data;
  logic        flush;

  int nchk = 0;
  int nerr = 0;

  alu_operand_issue dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [11:0] imm;
    logic        use_imm;
    logic [23:0] ea;
    logic [23:0] eb;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [11:0] imm, input logic use_imm,
                       input logic [2:0] rd, input logic wr_en);
    in_valid   = 1'b1;
    in_op      = op;
    in_rs      = rs;
    in_rt      = rt;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_rd      = rd;
    in_wr_en   = wr_en;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    in_use_imm = 1'b0; in_rd = '0; in_wr_en = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  // Drain the slice with nothing new offered.
  task automatic idle_cycle();
    @(negedge clk);
    idle_inputs();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [23:0] data);
    @(negedge clk);
    idle_inputs();
    wb_valid = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_alu_a"},     32'(alu_a),     32'h0);
    chk({tag, "_alu_b"},     32'(alu_b),     32'h0);
    chk({tag, "_alu_op"},    32'(alu_op),    32'h0);
    chk({tag, "_out_rd"},    32'(out_rd),    32'h0);
    chk({tag, "_out_wr_en"}, 32'(out_wr_en), 32'h0);
  endtask

  initial begin
    vecs[0] = '{3'd1, 3'd1, 3'd2, 12'h000, 1'b0, 24'h000010, 24'h000003};
    vecs[1] = '{3'd2, 3'd1, 3'd0, 12'hFFF, 1'b1, 24'h000010, 24'hFFFFFF};
    vecs[2] = '{3'd3, 3'd6, 3'd7, 12'h000, 1'b0, 24'h123456, 24'h800001};
    vecs[3] = '{3'd4, 3'd0, 3'd6, 12'h000, 1'b0, 24'h000000, 24'h123456};
    vecs[4] = '{3'd5, 3'd7, 3'd0, 12'h7FF, 1'b1, 24'h800001, 24'h0007FF};
    vecs[5] = '{3'd6, 3'd3, 3'd0, 12'h800, 1'b1, 24'h000013, 24'hFFF800};
    vecs[6] = '{3'd0, 3'd2, 3'd0, 12'h000, 1'b0, 24'h000003, 24'h000000};
    vecs[7] = '{3'd6, 3'd2, 3'd3, 12'h001, 1'b1, 24'h000003, 24'h000001};

    reset_n = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    wb(3'd1, 24'h000010);
    wb(3'd2, 24'h000003);
    wb(3'd6, 24'h123456);
    wb(3'd7, 24'h800001);

    // ADD R3 = R1 + R2
    @(negedge clk);
    drive(3'd0, 3'd1, 3'd2, 12'h000, 1'b0, 3'd3, 1'b1);
    #1 chk("add_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("add_out_valid", 32'(out_valid), 32'h1);
    chk("add_alu_a",     32'(alu_a),     32'h10);
    chk("add_alu_b",     32'(alu_b),     32'h3);
    chk("add_alu_op",    32'(alu_op),    32'h0);
    chk("add_out_rd",    32'(out_rd),    32'h3);
    chk("add_out_wr_en", 32'(out_wr_en), 32'h1);

    // RAW on R3: in_ready low with in_valid low too (pending[3] set).
    @(negedge clk);
    drive(3'd1, 3'd3, 3'd0, 12'h000, 1'b1, 3'd0, 1'b0);
    in_valid = 1'b0;
    #1 chk("raw_pending3_ready_novalid", 32'(in_ready), 32'h0);
    in_valid = 1'b1;
    #1 chk("raw_stall_0", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("raw_slice_drained", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1 chk("raw_stall_1", 32'(in_ready), 32'h0);
    wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 24'h000013;
    #1 chk("raw_wb_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("raw_out_valid",   32'(out_valid), 32'h1);
    chk("raw_bypass_a",    32'(alu_a),     32'h13);
    chk("raw_alu_op",      32'(alu_op),    32'h1);
    idle_cycle();

    // Table vectors, back-to-back with no hazards.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      out_ready = 1'b1;
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].use_imm, 3'd0, 1'b0);
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("vec%0d_alu_a", i),     32'(alu_a),     32'(vecs[i].ea));
      chk($sformatf("vec%0d_alu_b", i),     32'(alu_b),     32'(vecs[i].eb));
      chk($sformatf("vec%0d_alu_op", i),    32'(alu_op),    32'(vecs[i].op));
    end
    idle_cycle();

    // WAW on R4, with an immediate reader of pending R4 via rt ignored.
    @(negedge clk);
    drive(3'd0, 3'd1, 3'd2, 12'h000, 1'b0, 3'd4, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    drive(3'd2, 3'd1, 3'd4, 12'h005, 1'b1, 3'd0, 1'b0);
    #1 chk("imm_rt_ignored_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("imm_rt_ignored_b", 32'(alu_b), 32'h5);
    @(negedge clk);
    drive(3'd3, 3'd1, 3'd2, 12'h000, 1'b0, 3'd4, 1'b1);
    #1 chk("waw_stall_0", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    #1 chk("waw_stall_1", 32'(in_ready), 32'h0);
    wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 24'h000044;
    #1 chk("waw_wb_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("waw_out_valid", 32'(out_valid), 32'h1);
    chk("waw_out_rd",    32'(out_rd),    32'h4);
    chk("waw_alu_op",    32'(alu_op),    32'h3);
    @(negedge clk);
    idle_inputs();
    in_rs = 3'd4; in_use_imm = 1'b1;
    #1 chk("waw_set_wins_pending4", 32'(in_ready), 32'h0);
    wb(3'd4, 24'h000045);
    idle_cycle();

    // R0: never pending, reads 0, writeback ignored, no bypass.
    @(negedge clk);
    drive(3'd0, 3'd1, 3'd2, 12'h000, 1'b0, 3'd0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    drive(3'd1, 3'd0, 3'd0, 12'h000, 1'b0, 3'd0, 1'b1);
    wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 24'hABCDEF;
    #1 chk("r0_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("r0_a", 32'(alu_a), 32'h0);
    chk("r0_b", 32'(alu_b), 32'h0);
    chk("r0_wr_en", 32'(out_wr_en), 32'h0);
    idle_cycle();

    // Backpressure: hold X for 3 cycles, then load Y.
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd5, 3'd1, 3'd2, 12'h000, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk("bp_x_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3'd3, 3'd6, 3'd7, 12'h000, 1'b0, 3'd0, 1'b0);
      #1 chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("bp%0d_a", i),     32'(alu_a),     32'h10);
      chk($sformatf("bp%0d_b", i),     32'(alu_b),     32'h3);
      chk($sformatf("bp%0d_op", i),    32'(alu_op),    32'h5);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("bp_y_valid", 32'(out_valid), 32'h1);
    chk("bp_y_a",     32'(alu_a),     32'h123456);
    chk("bp_y_op",    32'(alu_op),    32'h3);
    idle_cycle();

    // Flush of a held writer of R5.
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd0, 3'd1, 3'd2, 12'h000, 1'b0, 3'd5, 1'b1);
    @(posedge clk); #1;
    chk("fl_held_rd", 32'(out_rd), 32'h5);
    @(negedge clk);
    drive(3'd2, 3'd5, 3'd0, 12'h000, 1'b1, 3'd0, 1'b0);
    flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    #1 chk("fl_r5_not_pending", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("fl_reader_valid", 32'(out_valid), 32'h1);
    chk("fl_reader_a",     32'(alu_a),     32'h0);
    idle_cycle();

    // Reset in the middle of a RAW stall.
    @(negedge clk);
    drive(3'd4, 3'd1, 3'd2, 12'h000, 1'b0, 3'd3, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd1, 3'd3, 3'd0, 12'h000, 1'b1, 3'd0, 1'b0);
    #1 chk("rst_pre_stall", 32'(in_ready), 32'h0);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(3'd2, 3'd1, 3'd0, 12'h000, 1'b1, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk("postrst_r1_cleared", 32'(alu_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
